jk_updown_counter: RTL
======================

# jk_updown_counter

Synchronous up/down counter with parallel load, built from one-bit JK storage cells. An excitation stage computes each bit's J/K pair every cycle from the current count and the control inputs, and feeds the JK cells directly. Serves as the counting front-end for timers and dividers in the basic-modules library. Exposes a terminal-count strobe and a sticky wrap flag.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- MODULUS, 10, wrap modulus; used only when the modulo feature is compiled in (2 ≤ MODULUS ≤ 2^WIDTH)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load request; has priority over en
- din  in  WIDTH  parallel load value
- clr_ovf  in  1  clears the sticky wrap flag
- q  out  WIDTH  current count, registered
- tc  out  1  terminal count, combinational from q/en/up
- ovf  out  1  sticky wrap flag, registered

## Operation
- Per-bit excitation codes ({J,K}): HOLD = 00, CLR = 01, SET = 10, TOG = 11.
- Priority, evaluated per cycle: load, then en, then hold.
- load=1: bit i receives SET if din[i]=1, otherwise CLR. en and up are ignored. ovf is unaffected.
- en=1, load=0, binary mode:
  - Up: bit i receives TOG when q[i-1:0] are all 1. Bit 0 always receives TOG.
  - Down: bit i receives TOG when q[i-1:0] are all 0. Bit 0 always receives TOG.
  - 2^WIDTH-1 wraps to 0 going up; 0 wraps to 2^WIDTH-1 going down.
- en=0, load=0: every bit receives HOLD, so q is unchanged.
- Terminal value:
  - Up: MAX, where MAX = 2^WIDTH-1 in binary mode and MODULUS-1 in modulo mode.
  - Down: 0.
- tc = en & ~load & (up ? q==MAX : q==0).
- Wrap: a wrap occurs on the cycle tc=1 at the clock edge, and it sets ovf.
- ovf:
  - Sticky; cleared by clr_ovf.
  - If set and clear occur on the same edge, set wins.
- Changing direction mid-count is legal and takes effect on the next edge with no penalty.

## Timing
- Reset (asynchronous): q = 0 and ovf = 0 immediately. tc then follows its combinational equation (for example, tc = 1 if en=1, up=0, load=0).
- Latency: q reflects load or count one clock edge after the inputs are sampled. ovf updates on the same edge as the wrapping count.
- tc has zero latency. It is valid in the same cycle as q and is intended for cascading a downstream enable.
- If rst is asserted in the middle of a load or count, the reset wins. The first operation after release uses the inputs sampled at the first rising edge with rst=0.

## Configuration
- JK_CNT_MODULO_EN defined:
  - The counter runs modulo MODULUS.
  - Up from any q ≥ MODULUS-1 forces all bits to CLR, so q becomes 0.
  - Down from 0 drives the SET/CLR pattern of MODULUS-1.
  - Otherwise the normal toggle rules apply. An out-of-range value loaded with load decrements normally.
- JK_CNT_MODULO_EN undefined: pure binary 2^WIDTH counter; MODULUS is ignored.

## Structure
- Package jk_pkg contains:
  - The 2-bit excitation typedef jk_op_t with constants JK_HOLD, JK_CLR, JK_SET, JK_TOG.
  - A function jk_from_target(cur, nxt) that returns the excitation code moving one bit from cur to nxt.
- Sub-module jk_cell: a one-bit JK storage element with clk, rst (asynchronous, active-high, Q resets to 0), j, k, q, qn. The counter instantiates WIDTH copies.
- The excitation logic and the ovf register live in the top level.

## Test plan
- Reset → up-count: rst pulse, then en=1, up=1 for 20 cycles with WIDTH=4 in binary mode → q steps 0..15 then 0..3. tc=1 at q=15; ovf rises on the edge to 0.
- Load priority: q=5, load=1, en=1, din=12 → q=12 next cycle with no count; then load=0, up=0 → 11, 10.
- Down wrap plus clear: q=0, en=1, up=0, clr_ovf=1 on the same edge → q=15 and ovf=1 (set beats clear). The next edge with clr_ovf=1 gives ovf=0.
- Modulo (JK_CNT_MODULO_EN, MODULUS=10): count up from 0 → 0..9, 0; tc=1 at 9. Count down from 0 → 9. Load 13 then count up → 0.
- Hold and asynchronous reset: en=0 for 5 cycles at q=7 → q stays 7 and tc=0. Assert rst between clock edges → q=0 and ovf=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared JK excitation encoding and helpers for the JK-cell counter family.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_t;

  // A differing bit toggles; a matching bit is re-asserted to its target level.
  function automatic jk_op_t jk_from_target(input logic cur, input logic nxt);
    if (cur != nxt) return JK_TOG;
    return nxt ? JK_SET : JK_CLR;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One-bit JK storage element with asynchronous active-high reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// Up/down counter with parallel load built from JK cells; sticky wrap flag.
// Define JK_CNT_MODULO_EN to make the counter wrap modulo MODULUS.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_param_check
    $error("jk_updown_counter: WIDTH must be >= 2 and 2 <= MODULUS <= 2**WIDTH");
  end

`ifdef JK_CNT_MODULO_EN
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
`endif

  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  jk_op_t           ops [WIDTH];
  logic             at_top;
  logic             at_zero;

  assign at_top  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign tc      = en & ~load & (up ? at_top : at_zero);

  // ones/zeros carry "all lower bits are 1/0" up the chain, replacing &q[i-1:0].
  always_comb begin : excitation
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ops[i] = JK_HOLD;
      if (load) begin
        ops[i] = din[i] ? JK_SET : JK_CLR;
      end else if (en) begin
`ifdef JK_CNT_MODULO_EN
        if (up && (q >= MAX_VAL)) ops[i] = JK_CLR;
        else if (!up && at_zero) ops[i] = jk_from_target(q[i], MAX_VAL[i]);
        else
`endif
        if (up ? ones : zeros) ops[i] = JK_TOG;
      end
      ones  = ones & q[i];
      zeros = zeros & qn[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign j[g] = ops[g][1];
    assign k[g] = ops[g][0];
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[g]),
      .k   (k[g]),
      .q   (q[g]),
      .qn  (qn[g])
    );
  end

  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (tc)      ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule
